// File: rtl/wb_stage_if.sv
// wb_stage_if: memory->writeback record bus, writeback->commit record bus and register-file write port
// Ports: i_* are driven toward the writeback stage, o_* are driven by it.
// slave modport is the writeback stage, master modport is its environment.
interface wb_stage_if;
  logic        i_wb_memoryed_req;
  logic        o_wb_memoryed_ack;
  logic [4:0]  i_wb_rd;
  logic        i_wb_rd_wen;
  logic [63:0] i_wb_rd_wdata;
  logic [63:0] i_wb_pc;
  logic [31:0] i_wb_inst;
  logic        i_wb_nocmt;
  logic        i_wb_skipcmt;
  logic        o_wb_writebacked_req;
  logic        i_wb_writebacked_ack;
  logic [4:0]  o_wb_rd;
  logic        o_wb_rd_wen;
  logic [63:0] o_wb_rd_wdata;
  logic [63:0] o_wb_pc;
  logic [31:0] o_wb_inst;
  logic        o_wb_nocmt;
  logic        o_wb_skipcmt;
  logic        o_wb_rf_wen;
  logic [4:0]  o_wb_rf_waddr;
  logic [63:0] o_wb_rf_wdata;
  logic [63:0] o_wb_instret;
  modport slave (
    input  i_wb_memoryed_req, i_wb_rd, i_wb_rd_wen, i_wb_rd_wdata, i_wb_pc, i_wb_inst,
           i_wb_nocmt, i_wb_skipcmt, i_wb_writebacked_ack,
    output o_wb_memoryed_ack, o_wb_writebacked_req, o_wb_rd, o_wb_rd_wen, o_wb_rd_wdata,
           o_wb_pc, o_wb_inst, o_wb_nocmt, o_wb_skipcmt, o_wb_rf_wen, o_wb_rf_waddr,
           o_wb_rf_wdata, o_wb_instret
  );
  modport master (
    output i_wb_memoryed_req, i_wb_rd, i_wb_rd_wen, i_wb_rd_wdata, i_wb_pc, i_wb_inst,
           i_wb_nocmt, i_wb_skipcmt, i_wb_writebacked_ack,
    input  o_wb_memoryed_ack, o_wb_writebacked_req, o_wb_rd, o_wb_rd_wen, o_wb_rd_wdata,
           o_wb_pc, o_wb_inst, o_wb_nocmt, o_wb_skipcmt, o_wb_rf_wen, o_wb_rf_waddr,
           o_wb_rf_wdata, o_wb_instret
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: 2-entry writeback buffer with req/ack toward commit, register-file write and instret counter
// Ports: clk, rst (async active-low), wb (wb_stage_if.slave: memory-side handshake and record,
// commit-side handshake and head record, rf write port, retired-instruction count).
module wb_stage #(
  parameter int DEPTH = 2
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave wb
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  typedef struct packed {
    logic [4:0]  rd;
    logic        rd_wen;
    logic [63:0] rd_wdata;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        nocmt;
    logic        skipcmt;
  } rec_t;
  state_t      state_q, state_d;
  logic        wp_q, rp_q, ack_q;
  rec_t        entry_q [DEPTH];
  rec_t        rec_in, head;
  logic [63:0] instret_q;
  logic        in_hs, out_hs;
  assign rec_in = {wb.i_wb_rd, wb.i_wb_rd_wen, wb.i_wb_rd_wdata, wb.i_wb_pc, wb.i_wb_inst,
                   wb.i_wb_nocmt, wb.i_wb_skipcmt};
  assign head   = entry_q[rp_q];
  assign in_hs  = wb.i_wb_memoryed_req & ack_q;
  assign out_hs = (state_q != EMPTY) & wb.i_wb_writebacked_ack;
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   state_d = in_hs ? ONE : EMPTY;
      ONE:     state_d = (in_hs == out_hs) ? ONE : (in_hs ? FULL : EMPTY);
      FULL:    state_d = out_hs ? ONE : FULL;
      default: state_d = EMPTY;
    endcase
  end
  // ack is registered from the next occupancy so it drops exactly while FULL
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      ack_q     <= 1'b1;
      instret_q <= '0;
      entry_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      ack_q   <= state_d != FULL;
      if (in_hs) begin
        entry_q[wp_q] <= rec_in;
        wp_q          <= ~wp_q;
      end
      if (out_hs) rp_q <= ~rp_q;
      if (out_hs & ~head.nocmt) instret_q <= instret_q + 64'd1;
    end
  end
  assign wb.o_wb_memoryed_ack    = ack_q;
  assign wb.o_wb_writebacked_req = state_q != EMPTY;
  assign wb.o_wb_rd              = head.rd;
  assign wb.o_wb_rd_wen          = head.rd_wen;
  assign wb.o_wb_rd_wdata        = head.rd_wdata;
  assign wb.o_wb_pc              = head.pc;
  assign wb.o_wb_inst            = head.inst;
  assign wb.o_wb_nocmt           = head.nocmt;
  assign wb.o_wb_skipcmt         = head.skipcmt;
  assign wb.o_wb_rf_wen          = out_hs & head.rd_wen & (head.rd != 5'd0) & ~head.nocmt;
  assign wb.o_wb_rf_waddr        = head.rd;
  assign wb.o_wb_rf_wdata        = head.rd_wdata;
  assign wb.o_wb_instret         = instret_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and randomized checks of wb_stage against a queue-based model
module tb_wb_stage;
  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        nocmt;
    logic        skip;
  } rec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  wb_stage_if wb();
  wb_stage #(.DEPTH(2)) dut (.clk(clk), .rst(rst), .wb(wb));
  always #5 clk = ~clk;
  rec_t        mq[$];
  rec_t        cur;
  logic [63:0] m_instret;
  int          tests = 0;
  int          fails = 0;
  function automatic rec_t mk(input logic [4:0] rd, input logic wen, input logic [63:0] pc,
                              input logic nocmt, input logic skip);
    rec_t r;
    r.rd = rd; r.wen = wen; r.wdata = pc; r.pc = pc; r.inst = 32'h13 ^ pc[31:0];
    r.nocmt = nocmt; r.skip = skip;
    return r;
  endfunction
  function automatic rec_t rnd();
    rec_t r;
    r.rd = 5'($urandom); r.wen = 1'($urandom); r.wdata = {$urandom, $urandom};
    r.pc = {$urandom, $urandom}; r.inst = $urandom;
    r.nocmt = 1'($urandom_range(3) == 0); r.skip = 1'($urandom_range(7) == 0);
    return r;
  endfunction
  function automatic rec_t dut_head();
    return {wb.o_wb_rd, wb.o_wb_rd_wen, wb.o_wb_rd_wdata, wb.o_wb_pc, wb.o_wb_inst,
            wb.o_wb_nocmt, wb.o_wb_skipcmt};
  endfunction
  task automatic drive(input logic req, input rec_t r, input logic ack);
    cur = r;
    wb.i_wb_memoryed_req = req; wb.i_wb_rd = r.rd; wb.i_wb_rd_wen = r.wen;
    wb.i_wb_rd_wdata = r.wdata; wb.i_wb_pc = r.pc; wb.i_wb_inst = r.inst;
    wb.i_wb_nocmt = r.nocmt; wb.i_wb_skipcmt = r.skip; wb.i_wb_writebacked_ack = ack;
  endtask
  // advance one clock, updating the model from the handshakes the bench itself offered
  task automatic tick();
    bit ih, oh;
    ih = wb.i_wb_memoryed_req && mq.size() < 2;
    oh = wb.i_wb_writebacked_ack && mq.size() > 0;
    @(posedge clk);
    if (oh) begin
      if (!mq[0].nocmt) m_instret += 64'd1;
      void'(mq.pop_front());
    end
    if (ih) mq.push_back(cur);
    @(negedge clk);
  endtask
  task automatic test_reset();
    drive(1'b1, mk(5'd1, 1'b1, 64'h100, 1'b0, 1'b0), 1'b1); tick();
    drive(1'b0, mk(5'd1, 1'b1, 64'h100, 1'b0, 1'b0), 1'b1); tick();
    drive(1'b1, mk(5'd2, 1'b1, 64'h104, 1'b0, 1'b0), 1'b0); tick();
    drive(1'b1, mk(5'd3, 1'b1, 64'h108, 1'b0, 1'b0), 1'b0); tick();
    drive(1'b0, mk(5'd3, 1'b1, 64'h108, 1'b0, 1'b0), 1'b0);
    #1;
    tests++; if (wb.o_wb_memoryed_ack !== 1'b0) begin fails++; $display("FAIL reset_prefull_ack got=%b exp=0", wb.o_wb_memoryed_ack); end
    tests++; if (wb.o_wb_instret !== 64'd1) begin fails++; $display("FAIL reset_pre_instret got=%0d exp=1", wb.o_wb_instret); end
    #2 rst = 1'b0;
    #1;
    tests++; if (wb.o_wb_writebacked_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", wb.o_wb_writebacked_req); end
    tests++; if (wb.o_wb_memoryed_ack !== 1'b1) begin fails++; $display("FAIL reset_ack got=%b exp=1", wb.o_wb_memoryed_ack); end
    tests++; if (wb.o_wb_instret !== 64'd0) begin fails++; $display("FAIL reset_instret got=%0d exp=0", wb.o_wb_instret); end
    mq.delete();
    m_instret = '0;
    drive(1'b0, '0, 1'b1);
    #1;
    tests++; if (wb.o_wb_rf_wen !== 1'b0) begin fails++; $display("FAIL reset_rfwen_in got=%b exp=0", wb.o_wb_rf_wen); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (wb.o_wb_rf_wen !== 1'b0) begin fails++; $display("FAIL reset_rfwen_after got=%b exp=0", wb.o_wb_rf_wen); end
      tests++; if (wb.o_wb_writebacked_req !== 1'b0) begin fails++; $display("FAIL reset_req_after got=%b exp=0", wb.o_wb_writebacked_req); end
      tick();
    end
  endtask
  task automatic test_streaming();
    logic exp_req;
    logic [63:0] epc;
    for (int i = 0; i < 6; i++) begin
      drive(i < 4, mk(5'(i + 1), 1'b1, 64'h80000000 + 64'(4 * i), 1'b0, 1'b0), 1'b1);
      #1;
      exp_req = (i >= 1 && i <= 4);
      epc = 64'h80000000 + 64'(4 * (i - 1));
      tests++; if (wb.o_wb_writebacked_req !== exp_req) begin fails++; $display("FAIL stream_req[%0d] got=%b exp=%b", i, wb.o_wb_writebacked_req, exp_req); end
      if (exp_req) begin
        tests++; if (wb.o_wb_pc !== epc) begin fails++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, wb.o_wb_pc, epc); end
        tests++; if ({wb.o_wb_rf_wen, wb.o_wb_rf_waddr, wb.o_wb_rf_wdata} !== {1'b1, 5'(i), epc}) begin
          fails++; $display("FAIL stream_rf[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, wb.o_wb_rf_wen, wb.o_wb_rf_waddr, wb.o_wb_rf_wdata, i, epc);
        end
      end
      tick();
    end
    #1;
    tests++; if (wb.o_wb_instret !== 64'd4) begin fails++; $display("FAIL stream_instret got=%0d exp=4", wb.o_wb_instret); end
  endtask
  task automatic test_backpressure();
    rec_t a, b, c;
    a = mk(5'd6, 1'b1, 64'h80000100, 1'b0, 1'b0);
    b = mk(5'd7, 1'b1, 64'h80000104, 1'b0, 1'b0);
    c = mk(5'd8, 1'b1, 64'h80000108, 1'b0, 1'b0);
    drive(1'b1, a, 1'b0); #1;
    tests++; if (wb.o_wb_memoryed_ack !== 1'b1) begin fails++; $display("FAIL bp_ack0 got=%b exp=1", wb.o_wb_memoryed_ack); end
    tick();
    drive(1'b1, b, 1'b0); #1;
    tests++; if (wb.o_wb_pc !== a.pc) begin fails++; $display("FAIL bp_pc_b got=%h exp=%h", wb.o_wb_pc, a.pc); end
    tick();
    drive(1'b1, c, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (wb.o_wb_memoryed_ack !== 1'b0) begin fails++; $display("FAIL bp_full_ack[%0d] got=%b exp=0", i, wb.o_wb_memoryed_ack); end
      tests++; if ({wb.o_wb_writebacked_req, wb.o_wb_pc} !== {1'b1, a.pc}) begin fails++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/%h", i, wb.o_wb_writebacked_req, wb.o_wb_pc, a.pc); end
      tests++; if (wb.o_wb_rf_wen !== 1'b0) begin fails++; $display("FAIL bp_rfwen[%0d] got=%b exp=0", i, wb.o_wb_rf_wen); end
      tick();
    end
    drive(1'b1, c, 1'b1); #1;
    tests++; if ({wb.o_wb_rf_wen, wb.o_wb_rf_waddr, wb.o_wb_memoryed_ack} !== {1'b1, 5'd6, 1'b0}) begin
      fails++; $display("FAIL bp_drain_a got=%b/%0d/%b exp=1/6/0", wb.o_wb_rf_wen, wb.o_wb_rf_waddr, wb.o_wb_memoryed_ack);
    end
    tick();
    #1;
    tests++; if ({wb.o_wb_memoryed_ack, wb.o_wb_pc} !== {1'b1, b.pc}) begin fails++; $display("FAIL bp_drain_b got=%b/%h exp=1/%h", wb.o_wb_memoryed_ack, wb.o_wb_pc, b.pc); end
    tick();
    drive(1'b0, c, 1'b1); #1;
    tests++; if ({wb.o_wb_writebacked_req, wb.o_wb_pc} !== {1'b1, c.pc}) begin fails++; $display("FAIL bp_drain_c got=%b/%h exp=1/%h", wb.o_wb_writebacked_req, wb.o_wb_pc, c.pc); end
    tick();
    #1;
    tests++; if (wb.o_wb_writebacked_req !== 1'b0) begin fails++; $display("FAIL bp_empty got=%b exp=0", wb.o_wb_writebacked_req); end
  endtask
  task automatic test_simultaneous();
    logic [63:0] epc;
    drive(1'b1, mk(5'd9, 1'b1, 64'h90000000, 1'b0, 1'b0), 1'b0); tick();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, mk(5'd9, 1'b1, 64'h90000000 + 64'(i), 1'b0, 1'b0), 1'b1); #1;
      epc = 64'h90000000 + 64'(i - 1);
      tests++; if ({wb.o_wb_writebacked_req, wb.o_wb_memoryed_ack, wb.o_wb_pc} !== {2'b11, epc}) begin
        fails++; $display("FAIL simul[%0d] got=%b/%b/%h exp=1/1/%h", i, wb.o_wb_writebacked_req, wb.o_wb_memoryed_ack, wb.o_wb_pc, epc);
      end
      tick();
    end
    drive(1'b0, '0, 1'b1); #1;
    tests++; if ({wb.o_wb_writebacked_req, wb.o_wb_pc} !== {1'b1, 64'h90000004}) begin fails++; $display("FAIL simul_last got=%b/%h exp=1/90000004", wb.o_wb_writebacked_req, wb.o_wb_pc); end
    tick();
    #1;
    tests++; if (wb.o_wb_writebacked_req !== 1'b0) begin fails++; $display("FAIL simul_empty got=%b exp=0", wb.o_wb_writebacked_req); end
  endtask
  task automatic test_x0_nocmt();
    rec_t r0, r1;
    logic [63:0] base;
    base = m_instret;
    r0 = mk(5'd0, 1'b1, 64'h80002000, 1'b0, 1'b0);
    r0.wdata = 64'hdead;
    r1 = mk(5'd5, 1'b1, 64'h80002004, 1'b1, 1'b0);
    drive(1'b1, r0, 1'b1); tick();
    drive(1'b1, r1, 1'b1); #1;
    tests++; if ({wb.o_wb_writebacked_req, wb.o_wb_pc, wb.o_wb_rf_wen} !== {1'b1, r0.pc, 1'b0}) begin
      fails++; $display("FAIL x0_write got=%b/%h/%b exp=1/%h/0", wb.o_wb_writebacked_req, wb.o_wb_pc, wb.o_wb_rf_wen, r0.pc);
    end
    tick();
    drive(1'b0, r1, 1'b1); #1;
    tests++; if ({wb.o_wb_nocmt, wb.o_wb_rf_wen} !== 2'b10) begin fails++; $display("FAIL nocmt_write got=%b/%b exp=1/0", wb.o_wb_nocmt, wb.o_wb_rf_wen); end
    tick();
    #1;
    tests++; if (wb.o_wb_instret !== base + 64'd1) begin fails++; $display("FAIL nocmt_instret got=%0d exp=%0d", wb.o_wb_instret, base + 64'd1); end
  endtask
  task automatic test_skipcmt();
    rec_t r;
    r = mk(5'd10, 1'b1, 64'h80001000, 1'b0, 1'b1);
    drive(1'b1, r, 1'b1); tick();
    drive(1'b0, r, 1'b1); #1;
    tests++; if ({wb.o_wb_skipcmt, wb.o_wb_pc} !== {1'b1, 64'h80001000}) begin fails++; $display("FAIL skip_fields got=%b/%h exp=1/80001000", wb.o_wb_skipcmt, wb.o_wb_pc); end
    tests++; if ({wb.o_wb_rf_wen, wb.o_wb_rf_waddr, wb.o_wb_rf_wdata} !== {1'b1, 5'd10, 64'h80001000}) begin
      fails++; $display("FAIL skip_rf got=%b/%0d/%h exp=1/10/80001000", wb.o_wb_rf_wen, wb.o_wb_rf_waddr, wb.o_wb_rf_wdata);
    end
    tick();
    #1;
    tests++; if (wb.o_wb_instret !== m_instret) begin fails++; $display("FAIL skip_instret got=%0d exp=%0d", wb.o_wb_instret, m_instret); end
  endtask
  task automatic test_random();
    logic ew;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(3) != 0), rnd(), 1'($urandom_range(2) != 0));
      #1;
      tests++; if (wb.o_wb_memoryed_ack !== 1'(mq.size() < 2)) begin fails++; $display("FAIL rnd_ack[%0d] got=%b exp=%b", i, wb.o_wb_memoryed_ack, mq.size() < 2); end
      tests++; if (wb.o_wb_writebacked_req !== 1'(mq.size() > 0)) begin fails++; $display("FAIL rnd_req[%0d] got=%b exp=%b", i, wb.o_wb_writebacked_req, mq.size() > 0); end
      ew = 1'b0;
      if (mq.size() > 0) begin
        tests++; if (dut_head() !== mq[0]) begin fails++; $display("FAIL rnd_head[%0d] got=%h exp=%h", i, dut_head(), mq[0]); end
        ew = wb.i_wb_writebacked_ack && mq[0].wen && mq[0].rd != 5'd0 && !mq[0].nocmt;
      end
      tests++; if (wb.o_wb_rf_wen !== ew) begin fails++; $display("FAIL rnd_rfwen[%0d] got=%b exp=%b", i, wb.o_wb_rf_wen, ew); end
      if (ew) begin
        tests++; if ({wb.o_wb_rf_waddr, wb.o_wb_rf_wdata} !== {mq[0].rd, mq[0].wdata}) begin
          fails++; $display("FAIL rnd_rf[%0d] got=%0d/%h exp=%0d/%h", i, wb.o_wb_rf_waddr, wb.o_wb_rf_wdata, mq[0].rd, mq[0].wdata);
        end
      end
      tests++; if (wb.o_wb_instret !== m_instret) begin fails++; $display("FAIL rnd_instret[%0d] got=%0d exp=%0d", i, wb.o_wb_instret, m_instret); end
      tick();
    end
  endtask
  initial begin
    m_instret = '0;
    drive(1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_x0_nocmt();
    test_skipcmt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the pipeline, and the sending end of the writeback-to-commit handshake. It accepts retired-instruction records from the memory stage into a 2-entry buffer. It presents the oldest record to the commit stage with a req/ack handshake. On each completed commit handshake it performs the architectural register-file write and counts retired instructions.

## Interface

Parameters:
- `DEPTH`, 2: buffer entries. The value is fixed at 2; the count register is 2 bits.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `i_wb_memoryed_req` in 1: memory stage offers a record.
- `o_wb_memoryed_ack` out 1: the buffer can accept a record; registered, equals `count != 2`.
- `i_wb_rd` in 5: destination register.
- `i_wb_rd_wen` in 1: destination write enable.
- `i_wb_rd_wdata` in 64: destination data.
- `i_wb_pc` in 64: instruction PC.
- `i_wb_inst` in 32: instruction word.
- `i_wb_nocmt` in 1: record is not a retired instruction (bubble or internal op).
- `i_wb_skipcmt` in 1: difftest must skip the next comparison (MMIO access).
- `o_wb_writebacked_req` out 1: head record valid toward the commit stage.
- `i_wb_writebacked_ack` in 1: commit stage accepts the record.
- `o_wb_rd`, `o_wb_rd_wen`, `o_wb_rd_wdata`, `o_wb_pc`, `o_wb_inst`, `o_wb_nocmt`, `o_wb_skipcmt` out 5/1/64/64/32/1/1: head record fields.
- `o_wb_rf_wen` out 1: register-file write strobe.
- `o_wb_rf_waddr` out 5: register-file write address.
- `o_wb_rf_wdata` out 64: register-file write data.
- `o_wb_instret` out 64: retired-instruction counter.

## Operation

- Input handshake `in_hs = i_wb_memoryed_req & o_wb_memoryed_ack`. Output handshake `out_hs = o_wb_writebacked_req & i_wb_writebacked_ack`.
- Storage is 2 entries indexed by 1-bit write pointer `wp` and 1-bit read pointer `rp`. The 2-bit `count` ranges 0..2. Pointers wrap from 1 to 0.
- State is fully described by `count`:
  - EMPTY (0): req low.
  - ONE (1): req high.
  - FULL (2): req high, ack low.
- On `in_hs`: the record is written to `entry[wp]`, `wp` toggles.
- On `out_hs`: `rp` toggles.
- Count update: `count += in_hs - out_hs`.
  - Simultaneous handshakes in ONE: count stays 1, both pointers advance.
  - Simultaneous handshakes in FULL cannot occur, because ack is low.
  - In EMPTY, a same-cycle input record is not forwarded combinationally. Latency is ≥1 cycle.
- `o_wb_writebacked_req = (count != 0)`. The `o_wb_*` record fields are `entry[rp]`. Fields are don't-care when req is low but must not be X after reset: entries reset to 0.
- Register-file write is combinational on `out_hs`:
  - `o_wb_rf_wen = out_hs & o_wb_rd_wen & (o_wb_rd != 0) & !o_wb_nocmt`.
  - `o_wb_rf_waddr = o_wb_rd`, `o_wb_rf_wdata = o_wb_rd_wdata`.
  - Writes to x0 are suppressed.
- `o_wb_instret` increments by 1 on each `out_hs` with `o_wb_nocmt == 0`. It wraps modulo 2^64.
- Req/ack rules toward commit:
  - Once raised, req and its record stay stable until ack is sampled high.
  - The commit stage may hold ack permanently high.

## Timing

- Reset (rst low, asynchronous) forces:
  - count=0, wp=rp=0, all entries=0, `o_wb_instret`=0.
  - `o_wb_memoryed_ack`=1, `o_wb_writebacked_req`=0, `o_wb_rf_wen`=0.
- Reset asserted mid-operation discards all buffered records immediately. No rf write or instret increment occurs during reset.
- Latency: a record accepted at edge N appears on req/fields after edge N. The earliest commit handshake is in cycle N+1.
- Throughput: one record per cycle when ack is held high.
- `o_wb_memoryed_ack` is low in exactly the cycles where count==2. It rises the cycle after a commit handshake drains FULL.
- The rf write and instret increment happen in the same cycle and at the same edge as `out_hs`. Exactly once per record.

## Test plan

- Reset: drive rst=0 mid-stream with 2 records buffered. Required: req=0, ack=1, instret=0 asynchronously. No rf_wen after release.
- Streaming: ack held high, 4 back-to-back records pc=0x80000000..0x8000000c with rd=1..4 and wdata=pc. Required: commit sees the 4 records in order, one per cycle, starting 1 cycle after the first accept. rf writes x1..x4. instret=4.
- Backpressure: commit ack=0, feed 3 records. Required: 2 accepted, memoryed_ack=0. Head pc is stable at the first record for 5 cycles. After ack=1, drain in order; the 3rd record is accepted the cycle after the first drain.
- Simultaneous: count=1, in_hs and out_hs in the same cycle. Required: count stays 1, order is preserved, no record is lost or duplicated.
- x0/nocmt: record rd=0, wen=1, wdata=0xdead, then record nocmt=1, rd=5, wen=1. Required: rf_wen=0 for both, instret increments by 1 only.
- skipcmt passthrough: record skipcmt=1, pc=0x80001000. Required: o_wb_skipcmt=1 with that pc at handshake. The rf write proceeds normally.
